mul_rr_arbiter: RTL and testbench
=================================

MUL_RR_ARBITER -- requirements
Module: mul_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 5, operand width in bits (signed two's complement).
REQ-002 Parameter N, default 4, number of requesters sharing the multiplier.
REQ-003 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N  per-requester request; bit i high means requester i presents operands.
REQ-007 a_in  input  N*WIDTH  operand A per requester; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-008 b_in  input  N*WIDTH  operand B per requester, same slicing as a_in.
REQ-009 gnt  output  N  registered one-hot grant; pulses high for one cycle when requester i's operands are latched.
REQ-010 busy  output  1  high while a product is in flight (state BUSY).
REQ-011 res_valid  output  1  one-cycle pulse marking a valid result.
REQ-012 res_id  output  clog2(N)  index of the requester that owns res.
REQ-013 res  output  2*WIDTH  signed product, held until the next res_valid.

Function
REQ-014 The block SHALL contain exactly one instance of the team's signed array multiplier (Mul, WIDTH parameter passed through), fed only from internal operand registers.
REQ-015 The FSM SHALL have two states: IDLE and BUSY.
REQ-016 IDLE, req == 0: the FSM SHALL remain in IDLE with gnt = 0.
REQ-017 IDLE, any req bit set: at the rising edge the FSM SHALL select winner w by round-robin, latch a_in/b_in slices of w into the operand registers, set gnt to one-hot w and cur_id = w, and enter BUSY.
REQ-018 Round-robin order: the search SHALL start at (ptr+1) mod N and wrap around; ptr SHALL be updated to w when the grant is issued.
REQ-019 BUSY: at the next edge the FSM SHALL capture the multiplier output into res, set res_id = cur_id, pulse res_valid, clear gnt, and return to IDLE.
REQ-020 Timing: with req sampled at edge k, gnt SHALL be high in cycle k+1 and res_valid in cycle k+2; a new grant is possible at edge k+2, so peak throughput is one product per 2 cycles.
REQ-021 The FSM SHALL NOT sample req in BUSY; a requester SHALL hold req and operands stable until it sees its gnt.
REQ-022 A req still high in the cycle after its gnt SHALL be treated as a new request.
REQ-023 res SHALL equal the exact signed product of the latched operands, sign-extended to 2*WIDTH bits; the full range, including (-2^(W-1))*(-2^(W-1)), SHALL be representable.
REQ-024 A requester whose req drops before it is granted SHALL be skipped with no gnt and no result.
REQ-025 Simultaneous requests SHALL be served in round-robin order; no requester SHALL wait more than N grants while continuously requesting.

Reset
REQ-026 While rst is high at an edge: state = IDLE, gnt = 0, busy = 0, res_valid = 0, res_id = 0, res = 0, operand registers = 0, ptr = N-1 (so requester 0 has first priority).
REQ-027 Reset asserted while BUSY SHALL discard the in-flight product; no res_valid SHALL follow.
REQ-028 rst SHALL take precedence over every other input in the same cycle.

Verification
REQ-029 Single request: req = 0001, a = 3, b = -5 (WIDTH = 5) -> gnt = 0001 in cycle +1; res_valid, res_id = 0, res = -15 (10'b1111110001) in cycle +2.
REQ-030 Extremes: a = -16, b = -16 -> res = 256; a = -16, b = 15 -> res = -240; a = 0, b = -7 -> res = 0.
REQ-031 Fairness: req = 1111 held continuously after reset -> grants 0, 1, 2, 3, 0 at 2-cycle spacing, with res_id matching each grant.
REQ-032 Wrap and skip: ptr = 2, req = 0011 -> grant 0, then 1; with req = 1000 dropped before its grant -> no gnt[3] and no result for id 3.
REQ-033 Reset mid-operation: rst pulsed in the BUSY cycle -> res_valid stays 0, all outputs are 0 the next cycle, and the next request from requester 0 is granted first.
REQ-034 Random regression: 10k random req/operand patterns -> every res equals a scoreboard signed product, and no requester waits more than N grants.

Source files
------------

// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter: shares one signed array multiplier among N requesters
// using round-robin arbitration. A winner's operands are latched on one
// edge, and the product is captured on the next, so at most one product
// is produced every two cycles.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   req[N]     per-requester request
//   a_in, b_in operands, requester i owns slice [i*WIDTH +: WIDTH]
//   gnt[N]     one-hot grant pulse, high in the cycle after operands latch
//   busy       high while a product is in flight
//   res_valid  one-cycle pulse when res/res_id are updated
//   res_id     owner of res
//   res        signed product, held until the next res_valid

// Mul: combinational signed array multiplier built from shifted partial
// products. The MSB of b carries negative weight (two's complement), so
// its partial product is subtracted instead of added.
module Mul #(
  parameter int WIDTH = 5
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] acc;

  always_comb begin
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    acc   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) begin
        if (i == WIDTH - 1) acc = acc - (a_ext <<< i);
        else                acc = acc + (a_ext <<< i);
      end
    end
    p = acc;
  end
endmodule

// State table
//   IDLE | waiting for a request; grants the round-robin winner
//   BUSY | winner's operands latched; product captured on next edge
module mul_rr_arbiter #(
  parameter int WIDTH = 5,
  parameter int N     = 4,
  localparam int IDW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   a_in,
  input  logic [N*WIDTH-1:0]   b_in,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [2*WIDTH-1:0]   res
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state;
  logic [IDW-1:0]            ptr;
  logic [IDW-1:0]            cur_id;
  logic signed [WIDTH-1:0]   op_a;
  logic signed [WIDTH-1:0]   op_b;
  logic signed [2*WIDTH-1:0] prod;

  logic [IDW-1:0]            win;
  logic [N-1:0]              win_onehot;
  logic                      found;
  int                        idx;

  Mul #(.WIDTH(WIDTH)) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // Search starts one past the last winner and wraps, so the most
  // recently served requester has the lowest priority.
  always_comb begin
    win        = '0;
    found      = 1'b0;
    idx        = 0;
    win_onehot = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    win_onehot[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      cur_id    <= '0;
      ptr       <= IDW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          res_valid <= 1'b0;
          if (found) begin
            op_a   <= a_in[int'(win)*WIDTH +: WIDTH];
            op_b   <= b_in[int'(win)*WIDTH +: WIDTH];
            gnt    <= win_onehot;
            cur_id <= win;
            ptr    <= win;
            busy   <= 1'b1;
            state  <= BUSY;
          end else begin
            gnt <= '0;
          end
        end
        BUSY: begin
          res       <= prod;
          res_id    <= cur_id;
          res_valid <= 1'b1;
          gnt       <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_rr_arbiter.sv
module tb_mul_rr_arbiter;
  localparam int W = 5;
  localparam int N = 4;
  localparam int IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req;
  logic [N*W-1:0]       a_in;
  logic [N*W-1:0]       b_in;
  logic [N-1:0]         gnt;
  logic                 busy;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [2*W-1:0]       res;

  int sa [N];
  int sb [N];

  int checks = 0;
  int errors = 0;

  // reference model state (transaction level, plain integers)
  bit           m_busy;
  int           m_ptr, m_cur, m_a, m_b;
  logic [N-1:0] e_gnt;
  bit           e_busy, e_valid;
  int           e_id, e_res;
  int           waits [N];

  mul_rr_arbiter #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res       (res)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign a_in[g*W +: W] = sa[g][W-1:0];
    assign b_in[g*W +: W] = sb[g][W-1:0];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update model from the inputs present at the edge, then
  // compare every DUT output just after the edge.
  task automatic step();
    int w;
    int worst;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_ptr = N - 1; m_cur = 0; m_a = 0; m_b = 0;
      e_gnt = '0; e_valid = 0; e_id = 0; e_res = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else if (m_busy) begin
      e_valid = 1; e_res = m_a * m_b; e_id = m_cur; e_gnt = '0; m_busy = 0;
    end else begin
      e_valid = 0; e_gnt = '0;
      if (req != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_a = sa[w]; m_b = sb[w]; m_cur = w; m_ptr = w;
        e_gnt[w] = 1'b1; m_busy = 1;
        worst = 0;
        for (int i = 0; i < N; i++) begin
          if (i == w || !req[i]) waits[i] = 0;
          else waits[i]++;
          if (waits[i] > worst) worst = waits[i];
        end
        chk("wait_bound", int'(worst <= N), 1);
      end
    end
    e_busy = m_busy;
    #1;
    chk("gnt", int'(gnt), int'(e_gnt));
    chk("busy", int'(busy), int'(e_busy));
    chk("res_valid", int'(res_valid), int'(e_valid));
    chk("res_id", int'(res_id), e_id);
    chk("res", int'($signed(res)), e_res);
  endtask

  typedef struct {
    int id;
    int a;
    int b;
    int exp_res;
  } vec_t;

  vec_t tbl [7];
  int   fair_exp [5];

  initial begin
    tbl[0] = '{0,   3,  -5,  -15};
    tbl[1] = '{1, -16, -16,  256};
    tbl[2] = '{2, -16,  15, -240};
    tbl[3] = '{3,   0,  -7,    0};
    tbl[4] = '{0,  -1,  -1,    1};
    tbl[5] = '{2,  15,  15,  225};
    tbl[6] = '{1,   7,  -8,  -56};
    fair_exp = '{0, 1, 2, 3, 0};

    rst = 1'b1; req = '0;
    for (int i = 0; i < N; i++) begin sa[i] = 0; sb[i] = 0; end
    step(); step();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_res", int'(res), 0);
    rst = 1'b0;
    step();

    // table: single requester transactions
    for (int t = 0; t < 7; t++) begin
      req = '0; req[tbl[t].id] = 1'b1;
      sa[tbl[t].id] = tbl[t].a; sb[tbl[t].id] = tbl[t].b;
      step();
      chk("tbl_gnt", int'(gnt), 1 << tbl[t].id);
      req = '0;
      step();
      chk("tbl_valid", int'(res_valid), 1);
      chk("tbl_id", int'(res_id), tbl[t].id);
      chk("tbl_res", int'($signed(res)), tbl[t].exp_res);
    end

    // fairness: all requesting from reset
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin sa[i] = i + 1; sb[i] = -2; end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fair_gnt", int'(gnt), 1 << fair_exp[k]);
      step();
      chk("fair_id", int'(res_id), fair_exp[k]);
      chk("fair_res", int'($signed(res)), -2 * (fair_exp[k] + 1));
    end

    // wrap and skip: ptr=2, then 3 drops before being served
    req = '0; step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b0100; step();
    chk("ws_g2", int'(gnt), 4'b0100);
    req = 4'b1011; step();
    req = 4'b0011; step();
    chk("ws_g0", int'(gnt), 4'b0001);
    req = 4'b0010; step();
    chk("ws_id0", int'(res_id), 0);
    step();
    chk("ws_g1", int'(gnt), 4'b0010);
    req = '0; step();
    chk("ws_id1", int'(res_id), 1);
    step();
    chk("ws_no3", int'(gnt[3]), 0);

    // reset while busy discards the product
    req = 4'b0100; sa[2] = 5; sb[2] = 5; step();
    chk("rb_busy", int'(busy), 1);
    req = 4'b1111; rst = 1'b1; step();
    chk("rb_valid", int'(res_valid), 0);
    chk("rb_res", int'(res), 0);
    chk("rb_gnt", int'(gnt), 0);
    rst = 1'b0; step();
    chk("rb_first", int'(gnt), 4'b0001);
    req = '0; step(); step();

    // random regression
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && !e_gnt[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else begin
          req[i] = 1'($urandom_range(0, 1));
          sa[i] = int'($urandom_range(0, 31)) - 16;
          sb[i] = int'($urandom_range(0, 31)) - 16;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
